// File: rtl/fp_unpack_norm_if.sv
// Operand/result bundle between an FPU operand source and fp_unpack_norm.
// Handshake: a transfer happens on a rising edge where valid & ready; a source
// holds valid and its payload until that edge, and ready may depend on state only.
interface fp_unpack_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_db;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [12:0] out_e;
    logic [52:0] out_f;
    logic        out_zero;
    logic        out_inf;
    logic        out_nan;
    logic        out_snan;
    logic        out_denorm;

    modport master (
        output in_valid, in_data, in_db, out_ready,
        input  in_ready, out_valid, out_s, out_e, out_f,
        input  out_zero, out_inf, out_nan, out_snan, out_denorm
    );

    modport slave (
        input  in_valid, in_data, in_db, out_ready,
        output in_ready, out_valid, out_s, out_e, out_f,
        output out_zero, out_inf, out_nan, out_snan, out_denorm
    );
endinterface

// File: rtl/fp_unpack_norm.sv
// Unpacks an IEEE single/double operand into sign, unbiased exponent and a
// 53-bit significand, normalizing denormals one shift step per cycle.
module fp_unpack_norm (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_unpack_norm_if.slave      bus,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic        s_q;
    logic [12:0] e_q;
    logic [52:0] f_q;
    logic        zero_q, inf_q, nan_q, snan_q, denorm_q;

    logic        sign_in;
    logic        exp_zero;
    logic        exp_ones;
    logic        frac_nz;
    logic [51:0] placed;
    logic [12:0] e_unb;
    logic [12:0] emin;

    // Single fraction is left-aligned so its MSB lands on bit 51 like double's.
    always_comb begin
        sign_in  = 1'b0;
        exp_zero = 1'b0;
        exp_ones = 1'b0;
        placed   = '0;
        e_unb    = '0;
        emin     = '0;
        if (bus.in_db) begin
            sign_in  = bus.in_data[63];
            exp_zero = (bus.in_data[62:52] == 11'd0);
            exp_ones = &bus.in_data[62:52];
            placed   = bus.in_data[51:0];
            e_unb    = {2'b00, bus.in_data[62:52]} - 13'd1023;
            emin     = 13'h1C02;
        end else begin
            sign_in  = bus.in_data[31];
            exp_zero = (bus.in_data[30:23] == 8'd0);
            exp_ones = &bus.in_data[30:23];
            placed   = {bus.in_data[22:0], 29'd0};
            e_unb    = {5'b00000, bus.in_data[30:23]} - 13'd127;
            emin     = 13'h1F82;
        end
        frac_nz = |placed;
    end

    logic        big_step;
    logic [52:0] f_step;
    logic [12:0] e_step;

    always_comb begin
        big_step = (f_q[52:45] == 8'd0);
        f_step   = big_step ? {f_q[44:0], 8'd0} : {f_q[51:0], 1'b0};
        e_step   = e_q - (big_step ? 13'd8 : 13'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_q      <= 1'b0;
            e_q      <= '0;
            f_q      <= '0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            snan_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_q      <= sign_in;
                        zero_q   <= 1'b0;
                        inf_q    <= 1'b0;
                        nan_q    <= 1'b0;
                        snan_q   <= 1'b0;
                        denorm_q <= 1'b0;
                        state    <= DONE;
                        if (exp_ones) begin
                            e_q    <= '0;
                            f_q    <= frac_nz ? {1'b0, placed} : 53'd0;
                            inf_q  <= ~frac_nz;
                            nan_q  <= frac_nz;
                            snan_q <= frac_nz & ~placed[51];
                        end else if (exp_zero && frac_nz) begin
                            e_q      <= emin;
                            f_q      <= {1'b0, placed};
                            denorm_q <= 1'b1;
                            state    <= NORM;
                        end else if (exp_zero) begin
                            e_q    <= '0;
                            f_q    <= '0;
                            zero_q <= 1'b1;
                        end else begin
                            e_q <= e_unb;
                            f_q <= {1'b1, placed};
                        end
                    end
                end
                NORM: begin
                    e_q <= e_step;
                    f_q <= f_step;
                    if (f_step[52]) state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_s      = s_q;
    assign bus.out_e      = e_q;
    assign bus.out_f      = f_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_inf    = inf_q;
    assign bus.out_nan    = nan_q;
    assign bus.out_snan   = snan_q;
    assign bus.out_denorm = denorm_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_fp_unpack_norm.sv
// Directed-vector bench for fp_unpack_norm: classification, denormal
// normalization latency, backpressure hold and mid-operation reset.
module tb_fp_unpack_norm;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_unpack_norm_if bus ();
    logic [1:0] state_dbg;

    fp_unpack_norm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    localparam int W = 72;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // flags order: {zero, inf, nan, snan, denorm}
    function automatic logic [W-1:0] pk(input logic s, input logic [12:0] e,
                                        input logic [52:0] f, input logic [4:0] fl);
        return {s, e, f, fl};
    endfunction

    function automatic logic [W-1:0] res_now();
        return {bus.out_s, bus.out_e, bus.out_f, bus.out_zero, bus.out_inf,
                bus.out_nan, bus.out_snan, bus.out_denorm};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input string tag, input logic db, input logic [63:0] data,
                        input int exp_lat, input logic [W-1:0] exp_res);
        int lat;
        exp_q.push_back(exp_res);
        check({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b1;
        bus.in_db    = db;
        bus.in_data  = data;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, W'(lat), W'(exp_lat));
        check({tag, "_res"}, res_now(), exp_q.pop_front());
        // out_ready is high, so the result leaves on the next edge
        @(posedge clk); #1;
        check({tag, "_released"}, W'({bus.out_valid, bus.in_ready}), W'(2'b01));
    endtask

    localparam logic [52:0] HID = 53'h10_0000_0000_0000;

    initial begin
        logic [W-1:0] held;
        int lat;
        bus.in_valid  = 1'b0;
        bus.in_db     = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_res", res_now(), '0);
        check("reset_hs", W'({bus.out_valid, bus.in_ready, state_dbg}), W'(4'b0100));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- normals ----------------
        send("d_1p5", 1'b1, 64'h3FF8_0000_0000_0000, 1,
             pk(1'b0, 13'd0, 53'h18_0000_0000_0000, 5'b00000));
        send("d_m2", 1'b1, 64'hC000_0000_0000_0000, 1,
             pk(1'b1, 13'd1, HID, 5'b00000));
        send("d_maxexp", 1'b1, 64'h7FE0_0000_0000_0000, 1,
             pk(1'b0, 13'h03FF, HID, 5'b00000));
        send("s_1p0", 1'b0, {32'($urandom_range(32'hFFFF_FFFF, 0)), 32'h3F80_0000}, 1,
             pk(1'b0, 13'd0, HID, 5'b00000));

        // ---------------- denormals ----------------
        send("s_den1", 1'b0, {32'($urandom_range(32'hFFFF_FFFF, 0)), 32'h0000_0001}, 10,
             pk(1'b0, 13'h1F6B, HID, 5'b00001));
        send("s_den_msb", 1'b0, 64'h0000_0000_0040_0000, 2,
             pk(1'b0, 13'h1F81, HID, 5'b00001));
        send("d_den1", 1'b1, 64'h0000_0000_0000_0001, 11,
             pk(1'b0, 13'h1BCE, HID, 5'b00001));
        send("d_den_msb", 1'b1, 64'h0008_0000_0000_0000, 2,
             pk(1'b0, 13'h1C01, HID, 5'b00001));
        send("d_den_b8", 1'b1, 64'h0000_0000_0000_0100, 10,
             pk(1'b0, 13'h1BD6, HID, 5'b00001));

        // ---------------- specials ----------------
        send("d_inf", 1'b1, 64'h7FF0_0000_0000_0000, 1,
             pk(1'b0, 13'd0, 53'd0, 5'b01000));
        send("s_snan", 1'b0, 64'h0000_0000_FF80_0001, 1,
             pk(1'b1, 13'd0, 53'h0000_2000_0000, 5'b00110));
        send("s_qnan", 1'b0, 64'h0000_0000_7FC0_0000, 1,
             pk(1'b0, 13'd0, 53'h08_0000_0000_0000, 5'b00100));
        send("d_negzero", 1'b1, 64'h8000_0000_0000_0000, 1,
             pk(1'b1, 13'd0, 53'd0, 5'b10000));

        // ---------------- backpressure ----------------
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_db     = 1'b1;
        bus.in_data   = 64'h3FF8_0000_0000_0000;
        @(posedge clk); #1;
        held = pk(1'b0, 13'd0, 53'h18_0000_0000_0000, 5'b00000);
        bus.in_data = 64'h7FF0_0000_0000_0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_hs", W'({bus.out_valid, bus.in_ready}), W'(2'b10));
            check("bp_res", res_now(), held);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
        send("after_bp", 1'b0, 64'h0000_0000_BF80_0000, 1,
             pk(1'b1, 13'd0, HID, 5'b00000));

        // ---------------- reset during NORM ----------------
        bus.in_valid = 1'b1;
        bus.in_db    = 1'b1;
        bus.in_data  = 64'h0000_0000_0000_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_norm_state", W'(state_dbg), W'(2'd1));
        rst_n = 1'b0;
        #1;
        check("rst_res", res_now(), '0);
        check("rst_hs", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = 0;
        send("after_rst", 1'b1, 64'h3FF8_0000_0000_0000, 1,
             pk(1'b0, 13'd0, 53'h18_0000_0000_0000, 5'b00000));
        check("sb_empty", W'(exp_q.size()), W'(lat));

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
